// File: rtl/bmem_rd_streamer_if.sv
// Memory-port and output-stream bundle for bmem_rd_streamer.
// master = streamer side; slave = memory/sink side.
interface bmem_rd_streamer_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  MEM_EN;
    logic [ADDR_WIDTH-1:0] MEM_ADDR;
    logic [DATA_WIDTH-1:0] MEM_DO;
    logic [DATA_WIDTH-1:0] M_TDATA;
    logic                  M_TVALID;
    logic                  M_TREADY;
    logic                  M_TLAST;

    modport master (
        output MEM_EN, MEM_ADDR, M_TDATA, M_TVALID, M_TLAST,
        input  MEM_DO, M_TREADY
    );

    modport slave (
        input  MEM_EN, MEM_ADDR, M_TDATA, M_TVALID, M_TLAST,
        output MEM_DO, M_TREADY
    );
endinterface

// File: rtl/bmem_rd_streamer.sv
// Streams LEN words from block-memory port B onto a valid/ready stream through a credit-controlled skid FIFO.
// Optional feature macro: BMEM_RD_ABORT_EN adds an ABORT input and a FLUSH state.
module bmem_rd_streamer #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  CLKA,
    input  logic                  RSTB,
    input  logic                  START,
    input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
    input  logic [ADDR_WIDTH:0]   LEN,
`ifdef BMEM_RD_ABORT_EN
    input  logic                  ABORT,
`endif
    output logic                  BUSY,
    output logic                  DONE,
    bmem_rd_streamer_if.master    bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH:0] LEN_ONE = 1;

`ifdef BMEM_RD_ABORT_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FLUSH} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
`endif

    state_t                state_q, state_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   remain_q, len_q, beat_q;
    logic [RD_LAT-1:0]     tag_q;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [7:0]            inflight;
    logic                  credit_ok, issue, push, pop, fifo_valid, last_beat, abort_w;

    // Credit counts reads still in the memory pipe, so the FIFO can never overflow.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + {7'b0, tag_q[i]};
        end
    end

    assign credit_ok  = (inflight + 8'(count_q)) < 8'(FIFO_DEPTH);
    assign issue      = (state_q == S_RUN) && credit_ok && !abort_w;
    assign fifo_valid = (count_q != '0);
    assign pop        = fifo_valid && bus.M_TREADY;
    assign last_beat  = fifo_valid && (beat_q == len_q - LEN_ONE);

`ifdef BMEM_RD_ABORT_EN
    logic [2:0] flush_cnt_q;

    assign abort_w = ABORT && ((state_q == S_RUN) || (state_q == S_DRAIN));
    assign push    = tag_q[RD_LAT-1] && !abort_w && (state_q != S_FLUSH);

    always_ff @(posedge CLKA) begin
        if (!RSTB) begin
            flush_cnt_q <= '0;
        end else if (abort_w) begin
            flush_cnt_q <= 3'(RD_LAT);
        end else if (state_q == S_FLUSH) begin
            flush_cnt_q <= flush_cnt_q - 3'd1;
        end
    end
`else
    assign abort_w = 1'b0;
    assign push    = tag_q[RD_LAT-1];
`endif

    always_ff @(posedge CLKA) begin
        if (!RSTB) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (LEN == '0) done_d  = 1'b1;
                    else           state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (issue && (remain_q == LEN_ONE)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (pop && last_beat) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
`ifdef BMEM_RD_ABORT_EN
            S_FLUSH: begin
                if (flush_cnt_q == 3'd1) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
`ifdef BMEM_RD_ABORT_EN
        if (abort_w) begin
            state_d = S_FLUSH;
            done_d  = 1'b0;
        end
`endif
    end

    // Valid tags mirror the memory read pipeline; the oldest one marks MEM_DO as live.
    always_ff @(posedge CLKA) begin
        if (!RSTB) tag_q[0] <= 1'b0;
        else       tag_q[0] <= issue;
    end

    generate
        for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_tag
            always_ff @(posedge CLKA) begin
                if (!RSTB) tag_q[gi] <= 1'b0;
                else       tag_q[gi] <= tag_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge CLKA) begin
        if (!RSTB) begin
            addr_q   <= '0;
            remain_q <= '0;
            len_q    <= '0;
            beat_q   <= '0;
        end else begin
            if ((state_q == S_IDLE) && START) begin
                addr_q   <= BASE_ADDR;
                remain_q <= LEN;
                len_q    <= LEN;
                beat_q   <= '0;
            end else begin
                if (issue) begin
                    addr_q   <= addr_q + ADDR_WIDTH'(1);
                    remain_q <= remain_q - LEN_ONE;
                end
                if (pop) beat_q <= beat_q + LEN_ONE;
            end
        end
    end

    always_ff @(posedge CLKA) begin
        if (!RSTB || abort_w) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge CLKA) begin
        if (push) fifo_mem[wr_ptr_q] <= bus.MEM_DO;
    end

    assign BUSY         = (state_q != S_IDLE);
    assign DONE         = done_q;
    assign bus.MEM_EN   = issue;
    assign bus.MEM_ADDR = addr_q;
    assign bus.M_TVALID = fifo_valid;
    assign bus.M_TDATA  = fifo_valid ? fifo_mem[rd_ptr_q] : '0;
    assign bus.M_TLAST  = last_beat;
endmodule

// File: tb/tb_bmem_rd_streamer.sv
// Self-checking bench for bmem_rd_streamer: memory model, expected-stream scoreboard and directed transfers.
`timescale 1ns/1ps
module tb_bmem_rd_streamer;
    localparam int AW     = 10;
    localparam int DW     = 32;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          lst;
    } beat_t;

    logic          CLKA = 1'b0;
    logic          RSTB = 1'b0;
    logic          START = 1'b0;
    logic [AW-1:0] BASE_ADDR = '0;
    logic [AW:0]   LEN = '0;
`ifdef BMEM_RD_ABORT_EN
    logic          ABORT = 1'b0;
`endif
    logic          BUSY, DONE;

    bmem_rd_streamer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bmem_rd_streamer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLKA(CLKA), .RSTB(RSTB), .START(START), .BASE_ADDR(BASE_ADDR), .LEN(LEN),
`ifdef BMEM_RD_ABORT_EN
        .ABORT(ABORT),
`endif
        .BUSY(BUSY), .DONE(DONE), .bus(bus)
    );

    always #5 CLKA = ~CLKA;

    // Memory port B: RD_LAT = 2 register stages between address and data.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] p1 = '0, p2 = '0;
    always @(posedge CLKA) begin
        if (bus.MEM_EN) p1 <= mem[bus.MEM_ADDR];
        p2 <= p1;
    end
    assign bus.MEM_DO = p2;

    beat_t         exp_q[$];
    logic [AW-1:0] ea_q[$];
    logic [AW-1:0] seen_addr[$];
    int            iss_q[$];
    int            checks = 0, errors = 0;
    int            ncyc = 0, pushed = 0, hs = 0;
    int            first_iss = -1, last_iss = -1, tlast_cnt = 0;
    bit            model_on = 1'b1, hold_v = 1'b0;
    logic [DW-1:0] hold_d = '0, tlast_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every issued address and every delivered beat must match the expected sequence.
    always @(negedge CLKA) begin
        ncyc++;
        if (!RSTB || !model_on) begin
            exp_q.delete(); ea_q.delete(); iss_q.delete();
            pushed = 0; hs = 0; hold_v = 1'b0;
        end else begin
            if (bus.MEM_EN) begin
                seen_addr.push_back(bus.MEM_ADDR);
                if (first_iss < 0) first_iss = ncyc;
                last_iss = ncyc;
                iss_q.push_back(ncyc);
                if (ea_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_mem_en: got addr 0x%0h required no read", bus.MEM_ADDR);
                end else begin
                    check("mem_addr", 64'(bus.MEM_ADDR), 64'(ea_q.pop_front()));
                end
            end
            if (hold_v) begin
                check("hold_valid", 64'(bus.M_TVALID), 64'(1));
                check("hold_data", 64'(bus.M_TDATA), 64'(hold_d));
            end
            while (iss_q.size() > 0 && iss_q[0] + RD_LAT + 1 <= ncyc) begin
                void'(iss_q.pop_front());
                pushed++;
            end
            checks++;
            if (pushed - hs > DEPTH) begin
                errors++;
                $display("FAIL fifo_occupancy: got %0d limit %0d", pushed - hs, DEPTH);
            end
            if (bus.M_TVALID) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got data 0x%0h required no beat", bus.M_TDATA);
                end else if (bus.M_TREADY) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_data", 64'(bus.M_TDATA), 64'(e.data));
                    check("beat_last", 64'(bus.M_TLAST), 64'(e.lst));
                    if (bus.M_TLAST) begin
                        tlast_cnt++;
                        tlast_data = bus.M_TDATA;
                    end
                    hs++;
                end
            end
            hold_v = bus.M_TVALID && !bus.M_TREADY;
            hold_d = bus.M_TDATA;
        end
    end

    task automatic load_model(input logic [AW-1:0] base, input int len);
        for (int i = 0; i < len; i++) begin
            logic [AW-1:0] a;
            a = base + AW'(i);
            ea_q.push_back(a);
            exp_q.push_back(beat_t'{mem[a], (i == len - 1)});
        end
    endtask

    // Called and returns at 1 ns after a rising edge; cycle 1 is the cycle after START is sampled.
    task automatic xfer(input logic [AW-1:0] base, input int len, input int mode, input int restart_at,
                        output int first_v, output int done_c, output logic [DW-1:0] fdata);
        first_v = -1; done_c = -1; fdata = '0;
        load_model(base, len);
        BASE_ADDR = base; LEN = len[AW:0]; START = 1'b1;
        @(posedge CLKA); #1;
        START = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            bus.M_TREADY = (mode == 0) ? 1'b1 : (cyc % 3 == 1);
            if (cyc == 1) check("busy_cycle1", 64'(BUSY), 64'(len != 0));
            if (cyc == restart_at) begin
                START = 1'b1; BASE_ADDR = 10'h200; LEN = 11'd5;
            end else begin
                START = 1'b0;
            end
            if (bus.M_TVALID && first_v < 0) begin
                first_v = cyc;
                fdata = bus.M_TDATA;
            end
            if (DONE) begin
                done_c = cyc;
                break;
            end
            @(posedge CLKA); #1;
        end
        START = 1'b0;
        bus.M_TREADY = 1'b1;
        checks++;
        if (done_c < 0) begin
            errors++;
            $display("FAIL done_timeout: got no DONE required DONE within 300 cycles");
        end
        check("busy_at_done", 64'(BUSY), 64'(0));
        check("addr_all_issued", 64'(ea_q.size()), 64'(0));
        check("beats_all_delivered", 64'(exp_q.size()), 64'(0));
        @(posedge CLKA); #1;
        check("done_single_pulse", 64'(DONE), 64'(0));
        $display("xfer base=0x%0h len=%0d first_valid=%0d done=%0d", base, len, first_v, done_c);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},   64'(BUSY),         64'(0));
        check({tag, "_done"},   64'(DONE),         64'(0));
        check({tag, "_mem_en"}, 64'(bus.MEM_EN),   64'(0));
        check({tag, "_addr"},   64'(bus.MEM_ADDR), 64'(0));
        check({tag, "_tdata"},  64'(bus.M_TDATA),  64'(0));
        check({tag, "_tvalid"}, 64'(bus.M_TVALID), 64'(0));
        check({tag, "_tlast"},  64'(bus.M_TLAST),  64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            fv, dc, hs_wait;
        logic [DW-1:0] fd;
        logic [AW-1:0] wrap_exp [4];
        wrap_exp = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i + 'h100);
        bus.M_TREADY = 1'b1;

        repeat (3) @(posedge CLKA);
        #1;
        check_outputs_zero("reset");
        RSTB = 1'b1;
        @(posedge CLKA); #1;

        // Basic 8-word transfer with ready held high.
        tlast_cnt = 0;
        xfer(10'h010, 8, 0, 0, fv, dc, fd);
        check("t1_first_valid_cycle", 64'(fv), 64'(4));
        check("t1_done_cycle", 64'(dc), 64'(12));
        check("t1_first_data", 64'(fd), 64'h110);
        check("t1_tlast_data", 64'(tlast_data), 64'h117);
        check("t1_tlast_count", 64'(tlast_cnt), 64'(1));

        // Address wrap at the top of memory.
        seen_addr.delete();
        xfer(10'h3FE, 4, 0, 0, fv, dc, fd);
        check("t2_read_count", 64'(seen_addr.size()), 64'(4));
        for (int i = 0; i < 4; i++) check("t2_wrap_addr", 64'(seen_addr[i]), 64'(wrap_exp[i]));

        // Backpressure: ready pattern 1,0,0 repeating.
        first_iss = -1; last_iss = -1;
        xfer(10'h040, 16, 1, 0, fv, dc, fd);
        check("t3_issue_stalled", 64'((last_iss - first_iss + 1) > 16), 64'(1));

        // Zero-length request.
        xfer(10'h123, 0, 0, 0, fv, dc, fd);
        check("t4_done_cycle", 64'(dc), 64'(1));
        check("t4_no_valid", 64'(fv), 64'(-1));

        // START while busy is ignored.
        xfer(10'h300, 4, 0, 3, fv, dc, fd);
        check("t5_done_cycle", 64'(dc), 64'(8));
        for (int i = 0; i < 6; i++) begin
            check("t5_idle_busy", 64'(BUSY), 64'(0));
            check("t5_idle_valid", 64'(bus.M_TVALID), 64'(0));
            check("t5_idle_mem_en", 64'(bus.MEM_EN), 64'(0));
            @(posedge CLKA); #1;
        end

        // Reset after three accepted beats of a 10-word transfer.
        load_model(10'h080, 10);
        BASE_ADDR = 10'h080; LEN = 11'd10; START = 1'b1;
        @(posedge CLKA); #1;
        START = 1'b0;
        hs_wait = 0;
        while (hs < 3 && hs_wait < 50) begin
            @(posedge CLKA); #1;
            hs_wait++;
        end
        check("t6_three_beats_seen", 64'(hs >= 3), 64'(1));
        RSTB = 1'b0;
        @(posedge CLKA); #1;
        check_outputs_zero("t6_reset");
        RSTB = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLKA); #1;
            check("t6_no_done", 64'(DONE), 64'(0));
            check("t6_idle", 64'(BUSY), 64'(0));
        end
        xfer(10'h0A0, 6, 0, 0, fv, dc, fd);
        check("t6_fresh_done_cycle", 64'(dc), 64'(10));
        check("t6_fresh_first_data", 64'(fd), 64'h1A0);

`ifdef BMEM_RD_ABORT_EN
        // Abort during beat index 2 of a 10-word transfer.
        model_on = 1'b0;
        @(posedge CLKA); #1;
        BASE_ADDR = 10'h000; LEN = 11'd10; START = 1'b1;
        @(posedge CLKA); #1;
        START = 1'b0;
        repeat (5) begin
            @(posedge CLKA); #1;
        end
        check("ab_beat2_valid", 64'(bus.M_TVALID), 64'(1));
        check("ab_beat2_data", 64'(bus.M_TDATA), 64'h102);
        ABORT = 1'b1;
        @(posedge CLKA); #1;
        ABORT = 1'b0;
        check("ab_valid_cleared", 64'(bus.M_TVALID), 64'(0));
        check("ab_busy_flush1", 64'(BUSY), 64'(1));
        check("ab_no_done1", 64'(DONE), 64'(0));
        @(posedge CLKA); #1;
        check("ab_busy_flush2", 64'(BUSY), 64'(1));
        check("ab_no_done2", 64'(DONE), 64'(0));
        @(posedge CLKA); #1;
        check("ab_idle", 64'(BUSY), 64'(0));
        check("ab_no_done3", 64'(DONE), 64'(0));
        check("ab_no_valid", 64'(bus.M_TVALID), 64'(0));
        $display("xfer abort base=0x0 len=10 aborted at beat 2");
        model_on = 1'b1;
        @(posedge CLKA); #1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bmem_rd_streamer.md
# bmem_rd_streamer

Read-side streaming engine that sits directly downstream of the dual-port block memory (`dp_bmem_behav` / `bram_dp_xpm`) port B. Given a start address and a length, it issues pipelined reads and returns the words on a valid/ready stream. A small credit-controlled skid FIFO absorbs the memory's fixed read latency, so downstream backpressure never drops data.

## Interface
- `ADDR_WIDTH`, 10: memory address width.
- `DATA_WIDTH`, 32: memory word width.
- `RD_LAT`, 2: memory read latency in cycles (1 + OUTPUT_REG); legal range 1..4.
- `FIFO_DEPTH`, 4: skid FIFO entries, power of two, ≥ `RD_LAT`+2.

- `CLKA`  in  1  clock; the block and the memory port run on the same clock.
- `RSTB`  in  1  reset, synchronous, active-low.
- `START`  in  1  single-cycle request; sampled only in IDLE.
- `BASE_ADDR`  in  ADDR_WIDTH  first address, captured with START.
- `LEN`  in  ADDR_WIDTH+1  word count 0..2^ADDR_WIDTH, captured with START.
- `BUSY`  out  1  high while not IDLE.
- `DONE`  out  1  one-cycle pulse when the final beat is accepted.
- `MEM_EN`  out  1  read enable to memory port (PIPE_EN/RE).
- `MEM_ADDR`  out  ADDR_WIDTH  read address.
- `MEM_DO`  in  DATA_WIDTH  memory read data, valid `RD_LAT` cycles after issue.
- `M_TDATA`  out  DATA_WIDTH  stream data.
- `M_TVALID`  out  1  stream valid.
- `M_TREADY`  in  1  stream ready.
- `M_TLAST`  out  1  high with the final beat.

## Operation
- FSM: IDLE → RUN on START with LEN≠0. IDLE stays in IDLE on START with LEN=0 and pulses DONE on the next cycle. RUN → DRAIN after the last read is issued. DRAIN → IDLE on acceptance of the beat with M_TLAST, with a DONE pulse.
- Issue rule: a read is issued in a cycle iff state=RUN and `inflight + fifo_count < FIFO_DEPTH`. No pop look-ahead.
- Each issue drives MEM_EN=1 and MEM_ADDR=current address, then increments the address modulo 2^ADDR_WIDTH (wraps 1023→0) and decrements the remaining count.
- A valid tag shift register of length `RD_LAT` tracks issued reads. When the tag emerges, MEM_DO is pushed into the FIFO. `inflight` equals the number of set tags.
- FIFO head drives M_TDATA/M_TVALID. A pop occurs on M_TVALID&M_TREADY. A push and a pop in the same cycle leave the count unchanged.
- M_TLAST is set on the beat whose stream index = LEN−1, using a beat counter on the output side.
- START while BUSY is ignored. M_TDATA holds its value while M_TVALID&!M_TREADY.
- Reset (any state, including mid-transfer): state IDLE, FIFO empty, tags cleared. All outputs 0: BUSY, DONE, MEM_EN, MEM_ADDR, M_TDATA, M_TVALID, M_TLAST. No DONE pulse follows.

## Timing
- START sampled at edge 0. First MEM_EN high in cycle 1. Its data is pushed at the end of cycle 1+RD_LAT, and M_TVALID rises in cycle 2+RD_LAT.
- With M_TREADY held high and FIFO_DEPTH ≥ RD_LAT+2, throughput is one beat/cycle. LEN words complete at cycle LEN+1+RD_LAT, with DONE high in the following cycle.
- BUSY rises in cycle 1 and falls the cycle DONE is high.
- Under backpressure, issue stalls within one cycle. Occupancy never exceeds FIFO_DEPTH.

## Configuration
- `BMEM_RD_ABORT_EN` defined: adds input port `ABORT` (1 bit).
  - ABORT high in RUN or DRAIN stops issuing in the same cycle and empties the FIFO at the next edge, so M_TVALID=0 from the next cycle.
  - Returning tags are discarded while in state FLUSH, which lasts `RD_LAT` cycles; the FSM then goes to IDLE.
  - No DONE pulse. BUSY stays high through FLUSH.
  - ABORT in IDLE is ignored.
- Not defined: no ABORT port and no FLUSH state. The transfer always runs to completion or reset.

## Test plan
- Memory preloaded with mem[i]=i+0x100. START, BASE_ADDR=0x010, LEN=8, M_TREADY=1 → beats 0x110..0x117 on consecutive cycles. First valid in cycle 4 (RD_LAT=2). M_TLAST only on 0x117. DONE one cycle after.
- BASE_ADDR=0x3FE, LEN=4 → reads addresses 0x3FE, 0x3FF, 0x000, 0x001 in order.
- LEN=16 with M_TREADY toggling 1,0,0,1,… → all 16 words delivered in order with no loss or duplication. fifo_count ≤ 4 every cycle. MEM_EN stalls when credits are exhausted.
- LEN=0 → DONE pulse in cycle 1, no MEM_EN, no M_TVALID. A second START during BUSY is ignored and yields no extra beats.
- RSTB=0 asserted after 3 beats of a LEN=10 transfer → next cycle all outputs 0 and IDLE. A fresh START then delivers its full sequence correctly.
- With `BMEM_RD_ABORT_EN`: ABORT during beat 2 of LEN=10 → M_TVALID=0 next cycle, BUSY high for 2 more cycles, then IDLE, no DONE.
